// File: rtl/serial_slice_alu.sv
// rtl/serial_slice_alu.sv - multi-cycle ALU processing SLICE bits per clock, LSB chunk first
module serial_slice_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       command,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, shadow;
    logic [2:0]       cmd_r;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             accept, last_chunk, subop;
    logic             c, bb, c_msb, cout, ovf, slt_bit;
    logic [SLICE-1:0] ch;
    logic [WIDTH-1:0] full;

    assign accept     = start && (state == S_IDLE || state == S_DONE);
    assign last_chunk = (state == S_RUN) && (cnt == CW'(N - 1));
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CW'(N - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are shifted right each chunk, so the working chunk is always bits [SLICE-1:0].
    always_comb begin
        subop = (cmd_r == OP_SUB) || (cmd_r == OP_SLT);
        c     = carry;
        bb    = 1'b0;
        c_msb = 1'b0;
        ch    = '0;
        for (int i = 0; i < SLICE; i++) begin
            bb = b_r[i] ^ subop;
            if (i == SLICE - 1) c_msb = c;
            ch[i] = a_r[i] ^ bb ^ c;
            c     = (a_r[i] & bb) | (c & (a_r[i] ^ bb));
        end
        cout = c;
        case (cmd_r)
            OP_XOR:  ch = a_r[SLICE-1:0] ^ b_r[SLICE-1:0];
            OP_AND:  ch = a_r[SLICE-1:0] & b_r[SLICE-1:0];
            OP_NAND: ch = ~(a_r[SLICE-1:0] & b_r[SLICE-1:0]);
            OP_NOR:  ch = ~(a_r[SLICE-1:0] | b_r[SLICE-1:0]);
            OP_OR:   ch = a_r[SLICE-1:0] | b_r[SLICE-1:0];
            default: ;
        endcase
        // Result enters from the top so the LSB chunk ends up at bit 0 after N steps.
        full    = (shadow >> SLICE) | (WIDTH'(ch) << (WIDTH - SLICE));
        ovf     = c_msb ^ cout;
        slt_bit = full[WIDTH-1] ^ ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= '0;
            b_r      <= '0;
            cmd_r    <= OP_ADD;
            cnt      <= '0;
            carry    <= 1'b0;
            shadow   <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            cmd_r <= command;
            cnt   <= '0;
            carry <= (command == OP_SUB) || (command == OP_SLT);
        end else if (state == S_RUN) begin
            a_r    <= a_r >> SLICE;
            b_r    <= b_r >> SLICE;
            shadow <= full;
            carry  <= cout;
            cnt    <= cnt + CW'(1);
            if (last_chunk) begin
                case (cmd_r)
                    OP_ADD, OP_SUB: begin
                        result   <= full;
                        carryout <= cout;
                        overflow <= ovf;
                        zero     <= (full == '0);
                    end
                    OP_SLT: begin
                        result   <= WIDTH'(slt_bit);
                        carryout <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= ~slt_bit;
                    end
                    default: begin
                        result   <= full;
                        carryout <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= (full == '0);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_slice_alu.sv
// tb/tb_serial_slice_alu.sv - directed self-checking bench for serial_slice_alu
module tb_serial_slice_alu;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] a, b;
    logic [2:0] command;
    logic       busy, done, carryout, overflow, zero;
    logic [7:0] result;

    logic       start2;
    logic [7:0] a2, b2;
    logic [2:0] command2;
    logic       busy2, done2, carryout2, overflow2, zero2;
    logic [7:0] result2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_slice_alu #(.WIDTH(8), .SLICE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .command(command),
        .busy(busy), .done(done), .result(result),
        .carryout(carryout), .overflow(overflow), .zero(zero)
    );

    serial_slice_alu #(.WIDTH(8), .SLICE(8)) dut_wide (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .command(command2),
        .busy(busy2), .done(done2), .result(result2),
        .carryout(carryout2), .overflow(overflow2), .zero(zero2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [7:0] r, input logic co,
                             input logic ov, input logic z);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " result"}, {24'd0, result}, {24'd0, r});
        chk({tag, " carryout"}, {31'd0, carryout}, {31'd0, co});
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, ov});
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, z});
    endtask

    // Start one op; busy must be high for exactly 4 samples, then done with the given values.
    task automatic run_op(input string tag, input logic [2:0] cmd, input logic [7:0] va,
                          input logic [7:0] vb, input logic [7:0] r, input logic co,
                          input logic ov, input logic z);
        start = 1'b1; a = va; b = vb; command = cmd;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " busy run"}, {30'd0, busy, done}, 32'd2);
            tick();
        end
        chk_flags(tag, r, co, ov, z);
        tick();
        chk({tag, " done pulse end"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; command = '0;
        start2 = 1'b0; a2 = '0; b2 = '0; command2 = '0;
        tick();
        tick();
        chk("reset outs", {busy, done, carryout, overflow, zero, 8'd0, result}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle busy", {31'd0, busy}, 32'd0);
        tick();
        chk("idle busy2", {30'd0, busy, done}, 32'd0);

        // Abort at chunk 2: nothing committed.
        start = 1'b1; a = 8'h7F; b = 8'h01; command = 3'b000;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy/done", {30'd0, busy, done}, 32'd0);
        chk("abort result", {24'd0, result}, 32'd0);
        tick();
        tick();
        tick();
        chk("abort no done", {30'd0, busy, done}, 32'd0);

        run_op("add 7f+01", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add ff+01", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub 05-05", 3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub 80-01", 3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("slt 80,01", 3'b011, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("slt 01,80", 3'b011, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("slt 7f,80", 3'b011, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("xor", 3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0);
        run_op("and", 3'b100, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0);
        run_op("nand", 3'b101, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0, 1'b0);
        run_op("nor", 3'b110, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0, 1'b0);
        run_op("or", 3'b111, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0);

        // Start and operand changes while running are ignored.
        start = 1'b1; a = 8'h10; b = 8'h20; command = 3'b000;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 8'hFF; b = 8'hFF; command = 3'b001;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_flags("ignore midrun", 8'h30, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ignore midrun idle", {30'd0, busy, done}, 32'd0);

        // Back-to-back: start held through DONE launches the next op immediately.
        start = 1'b1; a = 8'h01; b = 8'h02; command = 3'b000;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk_flags("b2b first", 8'h03, 1'b0, 1'b0, 1'b0);
        a = 8'h09; b = 8'h03; command = 3'b001;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b busy run", {30'd0, busy, done}, 32'd2);
            tick();
        end
        chk_flags("b2b second", 8'h06, 1'b1, 1'b0, 1'b0);
        tick();

        // Single-chunk instance: done two edges after start.
        start2 = 1'b1; a2 = 8'h7F; b2 = 8'h01; command2 = 3'b000;
        tick();
        start2 = 1'b0;
        chk("wide busy", {30'd0, busy2, done2}, 32'd2);
        tick();
        chk("wide done", {30'd0, busy2, done2}, 32'd1);
        chk("wide result", {21'd0, result2, carryout2, overflow2, zero2}, {21'd0, 8'h80, 3'b010});
        tick();
        chk("wide idle", {30'd0, busy2, done2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
